// File: rtl/flash_arb.sv
// flash_arb: round-robin arbiter sharing the flash read controller between the fetch (m0)
// and data (m1) ports, with a one-word read buffer, local write completion and a watchdog.
module flash_arb #(
  parameter int BUF_EN  = 1,
  parameter int TIMEOUT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ready_o,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ready_o,
  output logic [31:0] s_adr_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ready_i,
  input  logic        inv_i,
  output logic        wr_drop_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIT   = 3'd1,
    ST_FLASH = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nx_s;
  logic        g_r;
  logic        last_g_r;
  logic [19:0] adr_q_r;
  logic [7:0]  cnt_r;
  logic        buf_v_r;
  logic [19:0] buf_tag_r;
  logic [31:0] buf_dat_r;

  logic        gnt_v_s;
  logic        gnt_idx_s;
  logic        gnt_we_s;
  logic [19:0] gnt_tag_s;
  logic        hit_s;
  logic        timeout_s;
  logic        fill_s;
  logic        take_s;
  logic        done_s;
  logic        g_nx_s;
  logic [19:0] adr_nx_s;
  logic [31:0] rdat_s;
  logic        m0_ready_nx_s;
  logic        m1_ready_nx_s;
  logic [31:0] m0_dat_nx_s;
  logic [31:0] m1_dat_nx_s;
  logic        s_stb_nx_s;
  logic [31:0] s_adr_nx_s;
  logic        wr_drop_nx_s;
  logic        err_nx_s;
  logic        unused_s;

  // Only the word index inside the 4 MiB flash window takes part in addressing.
  assign unused_s = ^{m0_adr_i[31:22], m0_adr_i[1:0], m1_adr_i[31:22], m1_adr_i[1:0]};
  assign s_we_o   = 1'b0;

  // Request selection, buffer lookup and watchdog compare
  always_comb begin
    gnt_v_s = m0_stb_i | m1_stb_i;
    if (m0_stb_i && m1_stb_i) begin
      gnt_idx_s = ~last_g_r;
    end else begin
      gnt_idx_s = m1_stb_i;
    end
    if (gnt_idx_s) begin
      gnt_tag_s = m1_adr_i[21:2];
      gnt_we_s  = m1_we_i;
    end else begin
      gnt_tag_s = m0_adr_i[21:2];
      gnt_we_s  = m0_we_i;
    end
    hit_s     = (BUF_EN != 0) && buf_v_r && (gnt_tag_s == buf_tag_r);
    timeout_s = (cnt_r == CNT_LAST);
    fill_s    = (state_r == ST_FLASH) && s_ready_i;
    take_s    = (state_r == ST_IDLE) && gnt_v_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!gnt_v_s) begin
          state_nx_s = ST_IDLE;
        end else if (gnt_we_s) begin
          state_nx_s = ST_DONE;
        end else if (hit_s) begin
          state_nx_s = ST_HIT;
        end else begin
          state_nx_s = ST_FLASH;
        end
      end
      ST_HIT:   state_nx_s = ST_DONE;
      ST_FLASH: begin
        if (s_ready_i || timeout_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_FLASH;
        end
      end
      ST_DONE:  state_nx_s = ST_GAP;
      ST_GAP:   state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    if (take_s) begin
      g_nx_s   = gnt_idx_s;
      adr_nx_s = gnt_tag_s;
    end else begin
      g_nx_s   = g_r;
      adr_nx_s = adr_q_r;
    end
    case (state_r)
      ST_HIT:   rdat_s = buf_dat_r;
      ST_FLASH: rdat_s = s_ready_i ? s_dat_i : 32'hFFFF_FFFF;
      default:  rdat_s = 32'h0000_0000;
    endcase
    done_s        = (state_nx_s == ST_DONE);
    m0_ready_nx_s = done_s && !g_nx_s;
    m1_ready_nx_s = done_s && g_nx_s;
    m0_dat_nx_s   = m0_ready_nx_s ? rdat_s : 32'h0000_0000;
    m1_dat_nx_s   = m1_ready_nx_s ? rdat_s : 32'h0000_0000;
    s_stb_nx_s    = (state_nx_s == ST_FLASH);
    s_adr_nx_s    = s_stb_nx_s ? {10'b0, adr_nx_s, 2'b00} : 32'h0000_0000;
    wr_drop_nx_s  = take_s && gnt_we_s;
    err_nx_s      = (state_r == ST_FLASH) && !s_ready_i && timeout_s;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Grant bookkeeping, watchdog counter and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_r        <= 1'b0;
      last_g_r   <= 1'b1;
      adr_q_r    <= 20'h0_0000;
      cnt_r      <= 8'd0;
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
      m0_dat_o   <= 32'h0000_0000;
      m1_dat_o   <= 32'h0000_0000;
      s_stb_o    <= 1'b0;
      s_adr_o    <= 32'h0000_0000;
      wr_drop_o  <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      g_r        <= g_nx_s;
      adr_q_r    <= adr_nx_s;
      if (take_s) begin
        last_g_r <= gnt_idx_s;
      end
      cnt_r      <= (state_r == ST_FLASH) ? cnt_r + 8'd1 : 8'd0;
      m0_ready_o <= m0_ready_nx_s;
      m1_ready_o <= m1_ready_nx_s;
      m0_dat_o   <= m0_dat_nx_s;
      m1_dat_o   <= m1_dat_nx_s;
      s_stb_o    <= s_stb_nx_s;
      s_adr_o    <= s_adr_nx_s;
      wr_drop_o  <= wr_drop_nx_s;
      err_o      <= err_nx_s;
    end
  end

  // One-entry read buffer; an invalidate beats a simultaneous fill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_v_r   <= 1'b0;
      buf_tag_r <= 20'h0_0000;
      buf_dat_r <= 32'h0000_0000;
    end else begin
      if (inv_i) begin
        buf_v_r <= 1'b0;
      end else if (fill_s && (BUF_EN != 0)) begin
        buf_v_r <= 1'b1;
      end
      if (fill_s && (BUF_EN != 0)) begin
        buf_tag_r <= adr_q_r;
        buf_dat_r <= s_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_flash_arb.sv
// Bench for flash_arb: vector table of single accesses plus hand sequences for
// contention, invalidate-vs-fill, and reset during a flash access.
module tb_flash_arb;

  localparam int TIMEOUT = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] m0_adr_i = 32'h0, m1_adr_i = 32'h0;
  logic        m0_stb_i = 1'b0, m0_we_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o;
  logic        m0_ready_o, m1_ready_o, s_stb_o, s_we_o, wr_drop_o, err_o;
  logic [31:0] s_dat_i = 32'h0;
  logic        s_ready_i = 1'b0;
  logic        inv_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // controller model knobs
  int ctl_cnt = 0;
  int ctl_lat = 12;
  bit ctl_hang = 1'b0;
  bit inv_on_fill = 1'b0;
  bit inv_req = 1'b0;
  int exp_last = 1;

  typedef struct {
    logic [31:0] dat;
    int          port;
    int          edge_n;
    bit          err;
    bit          wr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          inv;
    int          port;
    logic [31:0] adr;
    bit          we;
    int          lat;
    bit          hang;
    logic [31:0] exp_dat;
    int          exp_edge;
    bit          exp_err;
    bit          exp_wr;
    bit          exp_flash;
    logic [31:0] exp_sadr;
  } vec_t;
  vec_t tbl[14];

  flash_arb #(.BUF_EN(1), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_dat_o(m0_dat_o), .m0_ready_o(m0_ready_o),
    .m1_adr_i(m1_adr_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_dat_o(m1_dat_o), .m1_ready_o(m1_ready_o),
    .s_adr_o(s_adr_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ready_i(s_ready_i),
    .inv_i(inv_i), .wr_drop_o(wr_drop_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h1122_3344;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Flash controller model: answers after ctl_lat strobed cycles unless hung
  always @(negedge clk_i) begin
    inv_i = inv_req;
    inv_req = 1'b0;
    if (s_stb_o && !s_ready_i) begin
      ctl_cnt++;
      if (!ctl_hang && ctl_cnt >= ctl_lat) begin
        s_ready_i = 1'b1;
        s_dat_i   = flash_word(s_adr_o);
        if (inv_on_fill) inv_i = 1'b1;
      end
    end else begin
      s_ready_i = 1'b0;
      s_dat_i   = 32'hDEAD_BEEF;
      ctl_cnt   = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int port, input logic [31:0] dat, input int edge_n,
                          input bit err, input bit wr);
    exp_t e;
    e.port = port; e.dat = dat; e.edge_n = edge_n; e.err = err; e.wr = wr;
    sb_q.push_back(e);
  endtask

  // Drive requests, pop the scoreboard on each ready, then watch a quiet tail.
  task automatic run_txn(input bit en0, input bit en1, input logic [31:0] a0, input logic [31:0] a1,
                         input bit we0, input bit we1, input bit exp_flash,
                         input logic [31:0] exp_sadr, input string tag);
    int edge_n = 0;
    int p;
    bit flash_seen = 1'b0;
    bit adr_bad = 1'b0;
    bit spur = 1'b0;
    exp_t e;
    m0_adr_i = a0; m0_we_i = we0; m0_stb_i = en0;
    m1_adr_i = a1; m1_we_i = we1; m1_stb_i = en1;
    while (sb_q.size() != 0 && edge_n < 80) begin
      @(posedge clk_i); #1;
      edge_n++;
      if (s_stb_o) begin
        flash_seen = 1'b1;
        if (s_adr_o !== exp_sadr) adr_bad = 1'b1;
      end
      if (s_we_o !== 1'b0) spur = 1'b1;
      if (m0_ready_o && m1_ready_o) spur = 1'b1;
      if ((err_o || wr_drop_o) && !(m0_ready_o || m1_ready_o)) spur = 1'b1;
      if (m0_ready_o || m1_ready_o) begin
        p = m1_ready_o ? 1 : 0;
        e = sb_q.pop_front();
        chk($sformatf("%s_port", tag), 32'(p), 32'(e.port));
        chk($sformatf("%s_dat", tag), p ? m1_dat_o : m0_dat_o, e.dat);
        chk($sformatf("%s_other_dat", tag), p ? m0_dat_o : m1_dat_o, 32'h0);
        chk($sformatf("%s_edge", tag), 32'(edge_n), 32'(e.edge_n));
        chk($sformatf("%s_err", tag), 32'(err_o), 32'(e.err));
        chk($sformatf("%s_wr_drop", tag), 32'(wr_drop_o), 32'(e.wr));
        if (p == 0) m0_stb_i = 1'b0;
        else        m1_stb_i = 1'b0;
      end
    end
    chk($sformatf("%s_pending", tag), 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (m0_ready_o || m1_ready_o || err_o || wr_drop_o || s_stb_o) spur = 1'b1;
    end
    chk($sformatf("%s_flash_used", tag), 32'(flash_seen), 32'(exp_flash));
    chk($sformatf("%s_s_adr", tag), 32'(adr_bad), 32'h0);
    chk($sformatf("%s_spurious", tag), 32'(spur), 32'h0);
  endtask

  task automatic rst_pulse();
    rst_i = 1'b1;
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_last = 1;
  endtask

  initial begin
    int first;
    bit bad;
    tbl[0]  = '{1'b0, 0, 32'h0000_0104, 1'b0, 12, 1'b0, 32'h1122_3344, 13, 1'b0, 1'b0, 1'b1, 32'h0000_0104};
    tbl[1]  = '{1'b0, 0, 32'h0000_0106, 1'b0, 12, 1'b0, 32'h1122_3344,  2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 0, 32'h0000_0104, 1'b0, 12, 1'b0, 32'h1122_3344, 13, 1'b0, 1'b0, 1'b1, 32'h0000_0104};
    tbl[3]  = '{1'b0, 1, 32'h0000_0200, 1'b1, 12, 1'b0, 32'h0000_0000,  1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1, 32'h0000_0107, 1'b0, 12, 1'b0, 32'h1122_3344,  2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1, 32'h0000_2000, 1'b0, 12, 1'b0, 32'h2000_DFFF, 13, 1'b0, 1'b0, 1'b1, 32'h0000_2000};
    tbl[6]  = '{1'b0, 0, 32'h0000_2003, 1'b0, 12, 1'b0, 32'h2000_DFFF,  2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 0, 32'h0040_0104, 1'b0, 12, 1'b0, 32'h1122_3344, 13, 1'b0, 1'b0, 1'b1, 32'h0000_0104};
    tbl[8]  = '{1'b0, 0, 32'h0000_3000, 1'b0, 12, 1'b1, 32'hFFFF_FFFF, TIMEOUT + 1, 1'b1, 1'b0, 1'b1, 32'h0000_3000};
    tbl[9]  = '{1'b0, 0, 32'h0000_0104, 1'b0, 12, 1'b0, 32'h1122_3344,  2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1, 32'h0000_0008, 1'b0,  1, 1'b0, 32'h0008_FFF7,  2, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
    tbl[11] = '{1'b0, 0, 32'h0000_0008, 1'b1, 12, 1'b0, 32'h0000_0000,  1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 0, 32'h0000_0009, 1'b0, 12, 1'b0, 32'h0008_FFF7,  2, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 0, 32'h0000_0040, 1'b0, TIMEOUT, 1'b0, 32'h0040_FFBF, TIMEOUT + 1, 1'b0, 1'b0, 1'b1, 32'h0000_0040};

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_m0_dat", m0_dat_o, 32'h0);
    chk("rst_m1_dat", m1_dat_o, 32'h0);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_flags", {25'h0, m0_ready_o, m1_ready_o, s_stb_o, s_we_o, wr_drop_o, err_o, 1'b0}, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].inv) begin
        inv_req = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
      end
      ctl_lat  = tbl[i].lat;
      ctl_hang = tbl[i].hang;
      push_exp(tbl[i].port, tbl[i].exp_dat, tbl[i].exp_edge, tbl[i].exp_err, tbl[i].exp_wr);
      run_txn(tbl[i].port == 0, tbl[i].port == 1, tbl[i].adr, tbl[i].adr, tbl[i].we, tbl[i].we,
              tbl[i].exp_flash, tbl[i].exp_sadr, $sformatf("vec%0d", i));
      exp_last = tbl[i].port;
      ctl_hang = 1'b0;
    end
    ctl_lat = 12;

    // invalidate arriving in the same cycle as a fill leaves the buffer empty
    inv_on_fill = 1'b1;
    push_exp(0, 32'h0600_F9FF, 13, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, "inv_fill");
    inv_on_fill = 1'b0;
    push_exp(0, 32'h0600_F9FF, 13, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, "reread_after_inv");

    // reset during a flash access; buffer (holding 0x600) must be lost
    m0_adr_i = 32'h0000_5000; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("mid_flash_stb", 32'(s_stb_o), 32'h1);
    rst_i = 1'b1;
    m0_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_drop_stb", 32'(s_stb_o), 32'h0);
    rst_i = 1'b0;
    exp_last = 1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (m0_ready_o || m1_ready_o || err_o || s_stb_o) bad = 1'b1;
    end
    chk("rst_no_ready", 32'(bad), 32'h0);
    push_exp(0, 32'h0600_F9FF, 13, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, "post_rst_miss");
    exp_last = 0;

    // contention from reset: round-robin order, one GAP between accesses
    rst_pulse();
    for (int r = 0; r < 3; r++) begin
      first = (exp_last == 1) ? 0 : 1;
      push_exp(first, 32'h0, 1, 1'b0, 1'b1);
      push_exp(1 - first, 32'h0, 4, 1'b0, 1'b1);
      exp_last = 1 - first;
      run_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0,
              $sformatf("arb%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
